// File: rtl/aes256_inv_cipher_core.sv
// Iterative AES inverse cipher: one inverse round per clock. Round keys are read
// combinationally from an external key-schedule store addressed by rk_idx.
module aes256_inv_cipher_core #(
  parameter int NR = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  // Handshake: a block moves on a rising edge where valid && ready are both high;
  // the producer holds data stable while valid is high and ready is low.

  localparam logic [3:0] KEY_LAST  = 4'(NR);
  localparam logic [3:0] CNT_START = 4'(NR - 1);

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [3:0]   cnt_q;
  logic [127:0] state_q;
  logic [127:0] sub_shift, round_xor, round_mix;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a, x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a     = col[31-8*i -: 8];
      x2    = xt(a);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a;
      mb[i] = x8 ^ x2 ^ a;
      md[i] = x8 ^ x4 ^ a;
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Row r of the output takes column (c - r) mod 4 of the input, then the S-box.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = INV_SBOX[s[127-8*(4*((c-r+4)%4)+r) -: 8]];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  assign sub_shift = inv_shift_sub(state_q);
  assign round_xor = sub_shift ^ rk_data;
  assign round_mix = inv_mix(round_xor);

  always_comb begin
    fsm_d    = fsm_q;
    in_ready = 1'b0;
    rk_idx   = KEY_LAST;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) fsm_d = ROUND;
      end
      ROUND: begin
        rk_idx = cnt_q;
        if (cnt_q == 4'd1) fsm_d = FINAL;
      end
      FINAL: begin
        rk_idx = 4'd0;
        fsm_d  = DONE;
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= IDLE;
      cnt_q     <= '0;
      state_q   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            state_q <= in_data ^ rk_data;
            cnt_q   <= CNT_START;
          end
        end
        ROUND: begin
          state_q <= round_mix;
          cnt_q   <= cnt_q - 4'd1;
        end
        FINAL: begin
          out_data  <= round_xor;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes256_inv_cipher_core.sv
// Bench for aes256_inv_cipher_core: ciphertexts come from an independent forward
// AES model, so each decrypted block must reproduce the original plaintext.
module tb_aes256_inv_cipher_core;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;

  logic [127:0] rk_mem [16];
  logic [7:0]   sbox [256];
  logic [7:0]   isbox [256];
  logic [127:0] exp_q [$];
  int           n_checks = 0;
  int           n_fails = 0;

  localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  always #5 clk = ~clk;

  assign rk_data = rk_mem[rk_idx];

  aes256_inv_cipher_core #(.NR(14)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b  = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
  endtask

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = isbox[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*((c+r)%4)+r) -: 8] = s[127-8*(4*c+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk_mem[0];
    for (int r = 1; r < 14; r++) s = mix_columns(shift_rows(sub_bytes(s))) ^ rk_mem[r];
    return shift_rows(sub_bytes(s)) ^ rk_mem[14];
  endfunction

  task automatic expand_key(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    rk_mem[15] = '0;
  endtask

  // ---------------- driver / monitor tasks ----------------
  task automatic send_block(input logic [127:0] ct, input logic [127:0] pt);
    int n;
    n = 0;
    exp_q.push_back(pt);
    in_data  = ct;
    in_valid = 1'b1;
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL send_accept: in_ready=%b required 1 within 64 cycles", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic recv_block(input int stall, input int exp_lat, input string name);
    int           n;
    logic [127:0] exp;
    n = 0;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fails++;
      $display("FAIL %s_queue: expected queue empty, required one entry", name);
      return;
    end
    exp = exp_q.pop_front();
    while (!out_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fails++;
      $display("FAIL %s_timeout: out_valid=%b after %0d cycles, required 1", name, out_valid, n);
      return;
    end
    if (exp_lat >= 0) begin
      n_checks++;
      if (n != exp_lat) begin
        n_fails++;
        $display("FAIL %s_latency: got %0d cycles, required %0d", name, n, exp_lat);
      end
    end
    n_checks++;
    if (out_data !== exp) begin
      n_fails++;
      $display("FAIL %s_data: got %h required %h", name, out_data, exp);
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
        n_fails++;
        $display("FAIL %s_hold: valid=%b ready=%b data=%h required valid=1 ready=0 data=%h",
                 name, out_valid, in_ready, out_data, exp);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b required 0 and 1", name, out_valid, in_ready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_flags: in_ready=%b out_valid=%b required 1 and 0", in_ready, out_valid);
    end
    n_checks++;
    if (out_data !== 128'h0) begin
      n_fails++;
      $display("FAIL reset_data: got %h required 0", out_data);
    end
    n_checks++;
    if (rk_idx !== 4'd14) begin
      n_fails++;
      $display("FAIL reset_rk_idx: got %0d required 14", rk_idx);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1 and 0", in_ready, out_valid);
    end
  endtask

  task automatic test_fips_vector();
    logic [3:0] exp_idx;
    expand_key(FIPS_KEY);
    in_data  = FIPS_CT;
    in_valid = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1 || rk_idx !== 4'd14) begin
      n_fails++;
      $display("FAIL fips_accept: in_ready=%b rk_idx=%0d required 1 and 14", in_ready, rk_idx);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k <= 14; k++) begin
      exp_idx = (k <= 12) ? 4'(13 - k) : ((k == 13) ? 4'd0 : 4'd14);
      n_checks++;
      if (rk_idx !== exp_idx) begin
        n_fails++;
        $display("FAIL fips_rk_idx: after edge E%0d got %0d required %0d", k, rk_idx, exp_idx);
      end
      n_checks++;
      if (out_valid !== (k == 14)) begin
        n_fails++;
        $display("FAIL fips_out_valid: after edge E%0d got %b required %b", k, out_valid, (k == 14));
      end
      if (k < 14) @(negedge clk);
    end
    n_checks++;
    if (out_data !== FIPS_PT) begin
      n_fails++;
      $display("FAIL fips_data: got %h required %h", out_data, FIPS_PT);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || rk_idx !== 4'd14) begin
      n_fails++;
      $display("FAIL fips_release: out_valid=%b in_ready=%b rk_idx=%0d required 0 1 14",
               out_valid, in_ready, rk_idx);
    end
  endtask

  // Last middle round must turn column 8e4da1bc into db135345 and leave 01010101 alone.
  task automatic test_inv_mix();
    logic [127:0] s1, pt, ct;
    for (int r = 0; r < 16; r++) rk_mem[r] = '0;
    s1 = {32'hdb135345, 32'h01010101, 32'h01010101, 32'h01010101};
    pt = inv_sub_bytes(inv_shift_rows(s1));
    ct = encrypt(pt);
    send_block(ct, pt);
    recv_block(0, 14, "invmix");
  endtask

  task automatic test_busy_backpressure();
    logic [127:0] pt2;
    expand_key(FIPS_KEY);
    send_block(FIPS_CT, FIPS_PT);
    repeat (3) @(negedge clk);
    in_data  = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fails++;
        $display("FAIL busy_in_ready: got %b required 0 during rounds", in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    recv_block(6, -1, "backpressure");
    pt2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    send_block(encrypt(pt2), pt2);
    recv_block(0, 14, "back_to_back");
  endtask

  task automatic test_reset_mid();
    int n;
    int seen;
    expand_key(FIPS_KEY);
    send_block(FIPS_CT, FIPS_PT);
    n = 0;
    while (rk_idx !== 4'd7 && n < 64) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (rk_idx !== 4'd7) begin
      n_fails++;
      $display("FAIL midreset_reach: rk_idx=%0d required 7", rk_idx);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 128'h0 || in_ready !== 1'b1 || rk_idx !== 4'd14) begin
      n_fails++;
      $display("FAIL midreset_state: valid=%b data=%h ready=%b rk_idx=%0d required 0 0 1 14",
               out_valid, out_data, in_ready, rk_idx);
    end
    void'(exp_q.pop_front());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fails++;
      $display("FAIL midreset_no_output: out_valid high for %0d cycles, required 0", seen);
    end
    send_block(FIPS_CT, FIPS_PT);
    recv_block(0, 14, "post_reset");
  endtask

  task automatic test_random();
    logic [255:0] key;
    logic [127:0] pt;
    for (int i = 0; i < 500; i++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
      pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      expand_key(key);
      send_block(encrypt(pt), pt);
      recv_block(int'($urandom_range(0, 5)), 14, "random");
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL random_leftover: %0d blocks outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_sbox();
    for (int r = 0; r < 16; r++) rk_mem[r] = '0;
    test_reset();
    test_fips_vector();
    test_inv_mix();
    test_busy_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
